// File: rtl/sync_fifo_pkg.sv
// Shared types and limits for the synchronous FIFO and its write-side arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package sync_fifo_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ_MAX = 16;

endpackage

// File: rtl/sync_fifo_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_owner,
// wrapping, found by masking a doubled request vector and priority-encoding it.
module sync_fifo_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_owner,
    output logic                found,
    output logic [ID_WIDTH-1:0] pick_id
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] masked_s;

    // Keep only the window last_owner+1 .. last_owner+NUM_REQ of the doubled vector.
    always_comb begin
        dbl_s    = {req, req};
        masked_s = {(2*NUM_REQ){1'b0}};
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            masked_s[i] = dbl_s[i] && (i > int'(last_owner)) && (i <= int'(last_owner) + NUM_REQ);
        end
    end

    // Lowest set bit of the window wins; its position folds back modulo NUM_REQ.
    always_comb begin
        found   = |masked_s;
        pick_id = {ID_WIDTH{1'b0}};
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (masked_s[i]) begin
                pick_id = ID_WIDTH'(i % NUM_REQ);
            end else begin
                pick_id = pick_id;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb_chk.sv
// Simulation-only protocol properties of the write arbiter outputs.
module sync_fifo_wr_arb_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               i_clk,
    input logic               i_rst_n,
    input logic [NUM_REQ-1:0] req_ready,
    input logic               fifo_valid,
    input logic               busy
);

    a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(req_ready));

    a_no_valid_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n) !busy |-> !fifo_valid);

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ valid/ready producers.
// Grants are bounded bursts; almost-full truncates a burst to the beat in flight.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sync_fifo_wr_arb
    import sync_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_almostfull,
    output logic                          o_fifo_valid,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy
);

    localparam int CNT_WIDTH = $clog2(BURST_MAX + 1);

    arb_state_t           state_r;
    arb_state_t           state_nxt_s;
    logic [ID_WIDTH-1:0]  owner_r;
    logic [ID_WIDTH-1:0]  last_owner_r;
    logic [CNT_WIDTH-1:0] beat_cnt_r;
    logic [ID_WIDTH-1:0]  pick_id_s;
    logic                 pick_found_s;
    logic                 owner_valid_s;
    logic                 accept_s;
    logic                 burst_done_s;
    logic                 release_s;

    sync_fifo_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (i_req_valid),
        .last_owner (last_owner_r),
        .found      (pick_found_s),
        .pick_id    (pick_id_s)
    );

    // Beat acceptance and release qualification for the current owner.
    always_comb begin
        owner_valid_s = i_req_valid[owner_r];
        accept_s      = (state_r == ARB_GRANT) && owner_valid_s && i_fifo_ready;
        burst_done_s  = (beat_cnt_r + CNT_WIDTH'(1)) == CNT_WIDTH'(BURST_MAX);
        // An abandoned grant releases without a transfer; otherwise only an accepted beat can end it.
        release_s     = (state_r == ARB_GRANT) &&
                        ((accept_s && (burst_done_s || i_fifo_almostfull)) || !owner_valid_s);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE:  state_nxt_s = pick_found_s ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: state_nxt_s = release_s ? ARB_IDLE : ARB_GRANT;
            default:   state_nxt_s = ARB_IDLE;
        endcase
    end

    // Owner, round-robin pointer and per-grant beat counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_r      <= {ID_WIDTH{1'b0}};
            last_owner_r <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else if (state_r == ARB_IDLE) begin
            if (pick_found_s) begin
                owner_r    <= pick_id_s;
                beat_cnt_r <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
            end
            if (release_s) begin
                last_owner_r <= owner_r;
            end
        end
    end

    // Output mux: the owner's stream passes straight through to the FIFO write port.
    always_comb begin
        o_busy       = (state_r == ARB_GRANT);
        o_grant_id   = owner_r;
        o_fifo_valid = 1'b0;
        o_fifo_data  = {DATA_WIDTH{1'b0}};
        o_req_ready  = {NUM_REQ{1'b0}};
        if (state_r == ARB_GRANT) begin
            o_fifo_valid = owner_valid_s;
            o_fifo_data  = i_req_data[int'(owner_r) * DATA_WIDTH +: DATA_WIDTH];
            o_req_ready  = NUM_REQ'(i_fifo_ready) << owner_r;
        end else begin
            o_fifo_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Randomised scoreboard bench for sync_fifo_wr_arb with a round-robin reference model.
module tb_sync_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int IW = 2;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic [N-1:0]    req_valid  = '0;
    logic [N*DW-1:0] req_data   = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_ready = 1'b1;
    logic            fifo_af    = 1'b0;
    logic            fifo_valid;
    logic [DW-1:0]   fifo_data;
    logic [IW-1:0]   grant_id;
    logic            busy;

    sync_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM), .ID_WIDTH(IW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .o_req_ready       (req_ready),
        .i_fifo_ready      (fifo_ready),
        .i_fifo_almostfull (fifo_af),
        .o_fifo_valid      (fifo_valid),
        .o_fifo_data       (fifo_data),
        .o_grant_id        (grant_id),
        .o_busy            (busy)
    );

    sync_fifo_wr_arb_chk #(.NUM_REQ(N)) chk (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .req_ready  (req_ready),
        .fifo_valid (fifo_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] plan_d [N][$];
    int            plan_g [N][$];
    logic [DW-1:0] exp_q  [N][$];
    int            grant_log[$];
    int            len_log[$];
    logic [N-1:0]  acc_vec    = '0;
    bit            rand_mode  = 1'b0;
    int            cyc        = 0;
    int            stall_from = -1;
    int            stall_to   = -1;
    bit            m_busy     = 1'b0;
    int            m_owner    = 0;
    int            m_last     = N - 1;
    int            m_cnt      = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_release();
        m_busy = 1'b0;
        m_last = m_owner;
        len_log.push_back(m_cnt);
    endfunction

    // Reference: one grant at a time, rotating priority, bounded bursts, one idle cycle per grant.
    task automatic monitor_cycle();
        int pick;
        check("busy", 32'(busy), 32'(m_busy));
        if (m_busy) begin
            check("grant_id", 32'(grant_id), 32'(m_owner));
            check("fifo_valid", 32'(fifo_valid), 32'(req_valid[m_owner]));
            check("req_ready", 32'(req_ready), fifo_ready ? (32'd1 << m_owner) : 32'd0);
            if (req_valid[m_owner] && fifo_ready) begin
                if (exp_q[m_owner].size() > 0)
                    check("data", 32'(fifo_data), 32'(exp_q[m_owner].pop_front()));
                m_cnt++;
                if (m_cnt == BM || fifo_af) model_release();
            end else if (!req_valid[m_owner]) begin
                model_release();
            end
        end else begin
            check("idle_fifo_valid", 32'(fifo_valid), 32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd0);
            pick = -1;
            for (int d = 1; d <= N; d++) begin
                if (pick < 0 && req_valid[(m_last + d) % N]) pick = (m_last + d) % N;
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_owner = pick;
                m_cnt   = 0;
                grant_log.push_back(pick);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
            end else begin
                monitor_cycle();
            end
            acc_vec = req_ready & req_valid;
        end
    end

    task automatic drive_step();
        logic [DW-1:0] d;
        cyc++;
        if (rand_mode) begin
            fifo_ready = ($urandom_range(0, 3) != 0);
            fifo_af    = ($urandom_range(0, 4) == 0);
        end else begin
            fifo_ready = !(cyc >= stall_from && cyc < stall_to);
        end
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && acc_vec[k]) req_valid[k] = 1'b0;
            if (!req_valid[k] && plan_d[k].size() > 0) begin
                if (plan_g[k][0] > 0) begin
                    plan_g[k][0] = plan_g[k][0] - 1;
                end else begin
                    d = plan_d[k].pop_front();
                    void'(plan_g[k].pop_front());
                    req_data[k*DW +: DW] = d;
                    req_valid[k] = 1'b1;
                    exp_q[k].push_back(d);
                end
            end
        end
    endtask

    task automatic add_beats(input int k, input int n, input logic [DW-1:0] base, input int gap_first);
        for (int i = 0; i < n; i++) begin
            plan_d[k].push_back(base + DW'(i));
            plan_g[k].push_back((i == 0) ? gap_first : 0);
        end
    endtask

    function automatic bit idle_all();
        for (int k = 0; k < N; k++) begin
            if (plan_d[k].size() > 0 || req_valid[k]) return 1'b0;
        end
        return !m_busy;
    endfunction

    task automatic run(input string name, input int max_cyc);
        int c;
        c = 0;
        while (c < max_cyc && !idle_all()) begin
            @(posedge clk); #1; drive_step(); c++;
        end
        repeat (2) begin
            @(posedge clk); #1; drive_step();
        end
        check({name, "_in_budget"}, 32'(c < max_cyc), 32'd1);
        for (int k = 0; k < N; k++) check({name, "_drained"}, 32'(exp_q[k].size()), 32'd0);
    endtask

    task automatic check_logs(input string name, input int eg[$], input int el[$]);
        check({name, "_grant_count"}, 32'(grant_log.size()), 32'(eg.size()));
        check({name, "_len_count"}, 32'(len_log.size()), 32'(el.size()));
        for (int i = 0; i < eg.size(); i++)
            check({name, "_grant"}, (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(eg[i]));
        for (int i = 0; i < el.size(); i++)
            check({name, "_len"}, (i < len_log.size()) ? 32'(len_log[i]) : 32'hFFFF_FFFF, 32'(el[i]));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_grant_id"}, 32'(grant_id), 32'd0);
        check({name, "_fifo_valid"}, 32'(fifo_valid), 32'd0);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_fifo_data"}, 32'(fifo_data), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < N; k++) begin
            plan_d[k].delete(); plan_g[k].delete(); exp_q[k].delete();
        end
        acc_vec = '0; rand_mode = 1'b0; fifo_af = 1'b0; fifo_ready = 1'b1;
        stall_from = -1; stall_to = -1; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        grant_log.delete();
        len_log.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int  eg[$];
        int  el[$];
        bit  hit;

        // Single producer, 10 beats: bursts 4,4,2.
        do_reset();
        add_beats(2, 10, 8'hA0, 0);
        run("single", 100);
        eg = {2, 2, 2}; el = {4, 4, 2};
        check_logs("single", eg, el);

        // All four continuously valid: strict rotation, full bursts.
        do_reset();
        for (int k = 0; k < N; k++) add_beats(k, 8, 8'(8'h10 * k), 0);
        run("all4", 200);
        eg = {0, 1, 2, 3, 0, 1, 2, 3}; el = {4, 4, 4, 4, 4, 4, 4, 4};
        check_logs("all4", eg, el);

        // FIFO backpressure for 5 cycles mid-burst.
        do_reset();
        add_beats(0, 8, 8'h60, 0);
        stall_from = 3; stall_to = 8;
        run("stall", 100);
        eg = {0, 0}; el = {4, 4};
        check_logs("stall", eg, el);

        // Almost-full: one beat per grant, alternating 1 and 3.
        do_reset();
        fifo_af = 1'b1;
        add_beats(1, 4, 8'h71, 0);
        add_beats(3, 4, 8'h83, 0);
        run("af", 100);
        eg = {1, 3, 1, 3, 1, 3, 1, 3}; el = {1, 1, 1, 1, 1, 1, 1, 1};
        check_logs("af", eg, el);
        fifo_af = 1'b0;

        // Owner 0 abandons after two beats while producer 1 waits.
        do_reset();
        add_beats(0, 2, 8'h10, 0);
        add_beats(0, 1, 8'h12, 3);
        add_beats(1, 2, 8'h20, 0);
        run("abandon", 100);
        eg = {0, 1, 0}; el = {2, 2, 1};
        check_logs("abandon", eg, el);

        // Reset during beat 3 of a grant to producer 1.
        do_reset();
        add_beats(1, 8, 8'h30, 0);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1; drive_step();
            if (m_busy && m_owner == 1 && m_cnt == 2) hit = 1'b1;
        end
        check("midrst_reached_beat3", 32'(hit), 32'd1);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        do_reset();
        add_beats(0, 2, 8'h40, 0);
        add_beats(1, 2, 8'h50, 0);
        run("midrst_after", 100);
        eg = {0, 1}; el = {2, 2};
        check_logs("midrst_after", eg, el);

        // Random traffic, gaps, backpressure and almost-full.
        do_reset();
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 25; i++) begin
                plan_d[k].push_back(8'($urandom));
                plan_g[k].push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            end
        end
        rand_mode = 1'b1;
        run("random", 3000);
        rand_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
